toggle_event_tx: RTL

- Multi-channel transmit side of a toggle-based clock-domain-crossing event link.
- Each channel converts single-cycle event pulses into toggles on `req`.
- The receiving domain returns the toggle level on `ack`; the block synchronises `ack` internally and uses it as a per-channel flow-control handshake.
- Events arriving while a crossing is in flight are counted and replayed, so none are lost up to counter saturation.
- Sits in the source clock domain, before a receiving toggle synchroniser that echoes `req` back as `ack`.

---
 rtl/toggle_resync_pkg.sv | 13 +
 rtl/toggle_event_chan.sv | 88 ++++++++
 rtl/toggle_event_tx.sv | 49 ++++
 3 files changed

// File: rtl/toggle_resync_pkg.sv
// Shared constants and helpers for the toggle event link.
package toggle_resync_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned CNT_W_DEFAULT   = 3;
  localparam int unsigned NCH_DEFAULT     = 4;

  // Largest value a pending counter of the given width can hold.
  function automatic int unsigned sat_value(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/toggle_event_chan.sv
// One transmit channel: ack synchroniser, pending-event counter, req toggle.
// Optional sticky overflow flag when TOGGLE_EVENT_TX_OVF_EN is defined.
module toggle_event_chan
  import toggle_resync_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rstb,
  input  logic a,
  input  logic ack,
  output logic req,
  output logic busy_c,
  output logic idle_c
`ifdef TOGGLE_EVENT_TX_OVF_EN
  ,
  input  logic ovf_clr,
  output logic ovf
`endif
);

  // A shorter chain would not be a synchroniser, so clamp to the minimum.
  localparam int unsigned SYNC_N =
    (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(sat_value(CNT_W));

  logic [SYNC_N-1:0] ack_sync;
  logic              ack_s;
  logic [CNT_W-1:0]  pending;
  logic [CNT_W-1:0]  pending_nxt;
  logic              issue;

  // Bring the remote ack toggle into the local clock domain.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_N-2:0], ack};
    end
  end

  assign ack_s  = ack_sync[SYNC_N-1];
  assign busy_c = req ^ ack_s;
  assign issue  = ~busy_c & ((pending != '0) | a);
  assign idle_c = ~busy_c & (pending == '0);

  // Pending count: new event adds one, an issue consumes one, saturate at max.
  always_comb begin
    pending_nxt = pending;
    if (issue) begin
      if (!a) begin
        pending_nxt = pending - CNT_W'(1);
      end
    end else if (a && (pending != PEND_MAX)) begin
      pending_nxt = pending + CNT_W'(1);
    end
  end

  // Request toggle and pending counter registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req     <= 1'b0;
      pending <= '0;
    end else begin
      req     <= req ^ issue;
      pending <= pending_nxt;
    end
  end

`ifdef TOGGLE_EVENT_TX_OVF_EN
  logic drop;

  assign drop = a & ~issue & (pending == PEND_MAX);

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/toggle_event_tx.sv
// Multi-channel transmit side of a toggle-based CDC event link.
// Define TOGGLE_EVENT_TX_OVF_EN to add per-channel ovf / ovf_clr ports.
module toggle_event_tx
  import toggle_resync_pkg::*;
#(
  parameter int unsigned NCH         = NCH_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic [NCH-1:0] a,
  output logic [NCH-1:0] req,
  input  logic [NCH-1:0] ack,
  output logic [NCH-1:0] busy,
  output logic           idle
`ifdef TOGGLE_EVENT_TX_OVF_EN
  ,
  output logic [NCH-1:0] ovf,
  input  logic [NCH-1:0] ovf_clr
`endif
);

  logic [NCH-1:0] chan_idle;

  // Independent channels, no arbitration between them.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    toggle_event_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk    (clk),
      .rstb   (rstb),
      .a      (a[i]),
      .ack    (ack[i]),
      .req    (req[i]),
      .busy_c (busy[i]),
      .idle_c (chan_idle[i])
`ifdef TOGGLE_EVENT_TX_OVF_EN
      ,
      .ovf_clr(ovf_clr[i]),
      .ovf    (ovf[i])
`endif
    );
  end

  assign idle = &chan_idle;

endmodule
